// File: rtl/dircc_types_pkg.sv
// Shared DiRCC fabric types: destination header layout and dispatcher FSM states.
package dircc_types_pkg;

  localparam int unsigned HDR_W        = 32;
  localparam int unsigned HW_ADDR_W    = 16;
  localparam int unsigned SW_ADDR_W    = 8;
  localparam int unsigned PORT_W       = 4;
  localparam int unsigned FLAG_W       = 4;
  localparam int unsigned FLAG_LSB     = 0;
  localparam int unsigned PORT_LSB     = FLAG_LSB + FLAG_W;
  localparam int unsigned SW_ADDR_LSB  = PORT_LSB + PORT_W;
  localparam int unsigned HW_ADDR_LSB  = SW_ADDR_LSB + SW_ADDR_W;
  localparam int unsigned DROP_CNT_W   = 16;

  typedef struct packed {
    logic [HW_ADDR_W-1:0] hw_addr;
    logic [SW_ADDR_W-1:0] sw_addr;
    logic [PORT_W-1:0]    port;
    logic [FLAG_W-1:0]    flag;
  } address_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELIVER = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Build a header word from its fields (transmit side).
  function automatic logic [HDR_W-1:0] dircc_header_pack(input address_t a);
    logic [HDR_W-1:0] w;
    w = '0;
    w[HW_ADDR_LSB +: HW_ADDR_W] = a.hw_addr;
    w[SW_ADDR_LSB +: SW_ADDR_W] = a.sw_addr;
    w[PORT_LSB    +: PORT_W]    = a.port;
    w[FLAG_LSB    +: FLAG_W]    = a.flag;
    return w;
  endfunction

  // Split a header word into its fields (receive side).
  function automatic address_t dircc_header_unpack(input logic [HDR_W-1:0] w);
    address_t a;
    a.hw_addr = w[HW_ADDR_LSB +: HW_ADDR_W];
    a.sw_addr = w[SW_ADDR_LSB +: SW_ADDR_W];
    a.port    = w[PORT_LSB    +: PORT_W];
    a.flag    = w[FLAG_LSB    +: FLAG_W];
    return a;
  endfunction

endpackage

// File: rtl/dircc_st_pipe_reg.sv
// One-entry Avalon-ST register slice carrying data, sop and eop.
module dircc_st_pipe_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready_c,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready
);

  // Slot may be refilled when empty or when its current beat is leaving.
  assign in_ready_c = !out_valid || out_ready;

  // Output register: load on accept, clear valid once drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_sop  <= in_sop;
        out_eop  <= in_eop;
      end
    end
  end

endmodule

// File: rtl/dircc_packet_dispatcher.sv
// Receive-side DiRCC endpoint: validates the destination header and forwards payload.
module dircc_packet_dispatcher
  import dircc_types_pkg::*;
#(
  parameter int unsigned HW_ADDR      = 0,
  parameter int unsigned DEVICE_COUNT = 1,
  parameter int unsigned INPUT_COUNT  = 1,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [SW_ADDR_W-1:0]  out_device,
  output logic [PORT_W-1:0]     out_port,
  output logic [FLAG_W-1:0]     out_flag,
  output logic [DROP_CNT_W-1:0] drop_count
);

  state_t   state, state_next;
  address_t hdr;
  logic     hdr_ok;
  logic     latch_hdr;
  logic     drop_inc;
  logic     pipe_valid;
  logic     pipe_ready;
  logic     first_pending;

  assign hdr    = dircc_header_unpack(HDR_W'(in_data));
  assign hdr_ok = (hdr.hw_addr == HW_ADDR_W'(HW_ADDR))
               && (32'(hdr.sw_addr) < DEVICE_COUNT)
               && (32'(hdr.port) < INPUT_COUNT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, ingress ready and per-beat control strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    latch_hdr  = 1'b0;
    drop_inc   = 1'b0;
    pipe_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_startofpacket) begin
            latch_hdr = 1'b1;
            if (in_endofpacket) drop_inc   = 1'b1;
            else if (hdr_ok)    state_next = ST_DELIVER;
            else                state_next = ST_DISCARD;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_DELIVER: begin
        in_ready   = pipe_ready;
        pipe_valid = in_valid;
        if (in_valid && pipe_ready && in_endofpacket) state_next = ST_IDLE;
      end
      ST_DISCARD: begin
        in_ready = 1'b1;
        if (in_valid && in_endofpacket) begin
          drop_inc   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) begin
      in_ready   = 1'b0;
      latch_hdr  = 1'b0;
      drop_inc   = 1'b0;
      pipe_valid = 1'b0;
    end
  end

  // Header fields held for the whole packet; SOP flag armed for the first payload beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_device    <= '0;
      out_port      <= '0;
      out_flag      <= '0;
      first_pending <= 1'b0;
    end else begin
      if (latch_hdr) begin
        out_device    <= hdr.sw_addr;
        out_port      <= hdr.port;
        out_flag      <= hdr.flag;
        first_pending <= 1'b1;
      end else if (pipe_valid && pipe_ready) begin
        first_pending <= 1'b0;
      end
    end
  end

  // Saturating discard counter.
  always_ff @(posedge clk) begin
    if (reset)                                  drop_count <= '0;
    else if (drop_inc && (drop_count != '1))    drop_count <= drop_count + DROP_CNT_W'(1);
  end

  dircc_st_pipe_reg #(.DATA_W(DATA_W)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (pipe_valid),
    .in_sop    (first_pending),
    .in_eop    (in_endofpacket),
    .in_ready_c(pipe_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_startofpacket),
    .out_eop   (out_endofpacket),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_dircc_packet_dispatcher.sv
// Scoreboard bench for dircc_packet_dispatcher (HW_ADDR=1, DEVICE_COUNT=2, INPUT_COUNT=1).
module tb_dircc_packet_dispatcher;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [7:0]  out_device;
  logic [3:0]  out_port;
  logic [3:0]  out_flag;
  logic [15:0] drop_count;

  dircc_packet_dispatcher #(
    .HW_ADDR(1), .DEVICE_COUNT(2), .INPUT_COUNT(1), .DATA_W(32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .out_device       (out_device),
    .out_port         (out_port),
    .out_flag         (out_flag),
    .drop_count       (drop_count)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [7:0]  dev;
    logic [3:0]  port;
    logic [3:0]  flag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   stall_cnt = 0;
  int   valid_seen = 0;
  bit   toggle_en = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) valid_seen++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_beat: got data 0x%0h with nothing expected", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_sop", 32'(out_startofpacket), 32'(e.sop));
          chk("beat_eop", 32'(out_endofpacket), 32'(e.eop));
          chk("beat_device", 32'(out_device), 32'(e.dev));
          chk("beat_port", 32'(out_port), 32'(e.port));
          chk("beat_flag", 32'(out_flag), 32'(e.flag));
        end
      end
    end
  end

  // Optional out_ready pattern 1,0,0,1 repeating.
  initial begin
    int idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        out_ready = pat[idx];
        idx = (idx + 1) % 4;
      end else begin
        idx = 0;
      end
    end
  end

  task automatic expect_beat(input logic [31:0] d, input logic s, input logic e,
                             input logic [7:0] dev, input logic [3:0] p, input logic [3:0] f);
    exp_t x;
    x.data = d; x.sop = s; x.eop = e; x.dev = dev; x.port = p; x.flag = f;
    exp_q.push_back(x);
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
    bit ok;
    ok = 0;
    in_data = d; in_startofpacket = s; in_endofpacket = e; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
      stall_cnt++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fails++;
      $display("FAIL accept_timeout: beat 0x%0h never accepted", d);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid_seen = 0;
    stall_cnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_drop_count", 32'(drop_count), 32'd0);
    chk("reset_out_device", 32'(out_device), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Port out of range: whole packet discarded.
    do_reset();
    send_beat(32'h0001_0110, 1'b1, 1'b0);
    send_beat(32'h0000_0111, 1'b0, 1'b0);
    send_beat(32'h0000_0222, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("badport_drop_count", 32'(drop_count), 32'd1);
    chk("badport_no_output", 32'(valid_seen), 32'd0);

    // Valid packet, full throughput, one-cycle latency.
    do_reset();
    expect_beat(32'hA, 1'b1, 1'b0, 8'd0, 4'd0, 4'd1);
    expect_beat(32'hB, 1'b0, 1'b1, 8'd0, 4'd0, 4'd1);
    send_beat(32'h0001_0001, 1'b1, 1'b0);
    chk("hdr_no_output", 32'(out_valid), 32'd0);
    send_beat(32'hA, 1'b0, 1'b0);
    chk("lat_a_valid", 32'(out_valid), 32'd1);
    chk("lat_a_data", out_data, 32'hA);
    send_beat(32'hB, 1'b0, 1'b1);
    chk("lat_b_data", out_data, 32'hB);
    chk("lat_b_eop", 32'(out_endofpacket), 32'd1);
    drain("good_drained");
    chk("good_stalls", 32'(stall_cnt), 32'd0);
    chk("good_drop_count", 32'(drop_count), 32'd0);

    // Same packet under out_ready 1,0,0,1 backpressure.
    do_reset();
    toggle_en = 1;
    expect_beat(32'hA, 1'b1, 1'b0, 8'd0, 4'd0, 4'd1);
    expect_beat(32'hB, 1'b0, 1'b1, 8'd0, 4'd0, 4'd1);
    send_beat(32'h0001_0001, 1'b1, 1'b0);
    send_beat(32'hA, 1'b0, 1'b0);
    send_beat(32'hB, 1'b0, 1'b1);
    drain("bp_drained");
    toggle_en = 0;
    #2;
    out_ready = 1'b1;
    n_checks++;
    if (stall_cnt == 0) begin
      n_fails++;
      $display("FAIL bp_in_ready_stall: got %0d stall cycles expected at least 1", stall_cnt);
    end

    // Wrong hw_addr packet then valid packet back-to-back.
    do_reset();
    expect_beat(32'hC, 1'b1, 1'b0, 8'd1, 4'd0, 4'd3);
    expect_beat(32'hD, 1'b0, 1'b1, 8'd1, 4'd0, 4'd3);
    send_beat(32'h0000_0000, 1'b1, 1'b0);
    send_beat(32'h1, 1'b0, 1'b0);
    send_beat(32'h2, 1'b0, 1'b0);
    send_beat(32'h3, 1'b0, 1'b1);
    send_beat(32'h0001_0103, 1'b1, 1'b0);
    send_beat(32'hC, 1'b0, 1'b0);
    send_beat(32'hD, 1'b0, 1'b1);
    drain("b2b_drained");
    chk("b2b_drop_count", 32'(drop_count), 32'd1);
    chk("b2b_stalls", 32'(stall_cnt), 32'd0);

    // Header-only packet then two strays.
    do_reset();
    send_beat(32'h0001_0001, 1'b1, 1'b1);
    send_beat(32'h77, 1'b0, 1'b0);
    send_beat(32'h88, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("hdronly_drop_count", 32'(drop_count), 32'd3);
    chk("hdronly_no_output", 32'(valid_seen), 32'd0);

    // Reset during the second payload beat of four.
    do_reset();
    expect_beat(32'h10, 1'b1, 1'b0, 8'd0, 4'd0, 4'd1);
    send_beat(32'h0001_0001, 1'b1, 1'b0);
    send_beat(32'h10, 1'b0, 1'b0);
    in_data = 32'h11; in_valid = 1'b1; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_drop_zero", 32'(drop_count), 32'd0);
    send_beat(32'h12, 1'b0, 1'b0);
    send_beat(32'h13, 1'b0, 1'b1);
    chk("rst_strays_drop", 32'(drop_count), 32'd2);
    expect_beat(32'h55, 1'b1, 1'b1, 8'd0, 4'd0, 4'd1);
    send_beat(32'h0001_0001, 1'b1, 1'b0);
    send_beat(32'h55, 1'b0, 1'b1);
    drain("rst_recover_drained");
    chk("rst_final_drop", 32'(drop_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dircc_packet_dispatcher.md
# dircc_packet_dispatcher

Receive-side endpoint for the DiRCC message fabric: accepts packets arriving at a hardware node, decodes the destination `address_t` header written by the sending device's fanout logic, validates it against the local node, and delivers the payload to the addressed device instance and input port. It sits between the node's network ingress (Avalon-ST) and the per-thread device handler logic. Misaddressed or malformed packets are discarded whole and counted.

## Interface
- `HW_ADDR`, 0: hardware address of this node; header `hw_addr` must equal it.
- `DEVICE_COUNT`, 1: device instances on this node; valid `sw_addr` is 0..DEVICE_COUNT-1.
- `INPUT_COUNT`, 1: input ports per device; valid `port` is 0..INPUT_COUNT-1.
- `DATA_W`, 32: beat width; must be 32.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  32  ingress beat.
- `in_valid`  in  1  ingress beat valid.
- `in_ready`  out  1  ingress backpressure.
- `in_startofpacket`  in  1  first beat (header).
- `in_endofpacket`  in  1  last beat.
- `out_data`  out  32  payload beat to device handler.
- `out_valid`  out  1  payload valid.
- `out_ready`  in  1  handler backpressure.
- `out_startofpacket`  out  1  first payload beat.
- `out_endofpacket`  out  1  last payload beat.
- `out_device`  out  8  decoded `sw_addr`, stable for the whole packet.
- `out_port`  out  4  decoded input port, stable for the whole packet.
- `out_flag`  out  4  header flag, passed through.
- `drop_count`  out  16  saturating count of discarded packets and stray beats.

## Operation
- Header word layout: [31:16] hw_addr, [15:8] sw_addr, [7:4] port, [3:0] flag.
- FSM states: IDLE, DELIVER, DISCARD.
- IDLE: `in_ready`=1. Beat with `in_startofpacket`=1 is the header; it is consumed, never forwarded. Fields are latched into `out_device`/`out_port`/`out_flag`.
  - Valid header (hw_addr==HW_ADDR, sw_addr<DEVICE_COUNT, port<INPUT_COUNT) without EOP -> DELIVER; the next forwarded beat carries `out_startofpacket`=1.
  - Invalid header without EOP -> DISCARD.
  - Header with EOP (header-only packet) -> malformed: `drop_count`+1, stay IDLE.
  - Beat without SOP in IDLE (stray) -> discarded, `drop_count`+1, stay IDLE.
- DELIVER: payload beats pass through a one-entry output register. `in_ready` = !`out_valid` || `out_ready`. Beat with `in_endofpacket` is forwarded with `out_endofpacket`=1, FSM -> IDLE on acceptance. `in_startofpacket` is ignored outside IDLE.
- DISCARD: `in_ready`=1. Beats are consumed silently; on the EOP beat `drop_count`+1 and FSM -> IDLE.
- `drop_count` saturates at 0xFFFF; it never wraps.
- `out_device`/`out_port`/`out_flag` change only when a header is latched in IDLE.

## Timing
- Reset values: `in_ready`=0 in the reset cycle, then 1 (IDLE); `out_valid`=0; `out_startofpacket`=0; `out_endofpacket`=0; `out_data`=0; `out_device`=0; `out_port`=0; `out_flag`=0; `drop_count`=0; FSM=IDLE.
- Payload latency: beat accepted at edge N is presented on `out_*` after edge N, and held until `out_valid`&&`out_ready`.
- Full throughput (one beat per clock) in DELIVER when `out_ready` is held high.
- The header costs one ingress cycle with no output beat.
- After an EOP beat is accepted, the next cycle is IDLE, so back-to-back packets incur no bubble on ingress.
- Reset mid-packet: FSM -> IDLE, the output register is cleared, and the beat in flight is lost. Remaining upstream beats of that packet arrive as strays and each one increments `drop_count`.

## Structure
- `dircc_types_pkg`: `address_t`, header field offsets/widths, and pack/unpack functions `dircc_header_pack`/`dircc_header_unpack` shared with the transmit-side fanout block.
- Sub-module `dircc_st_pipe_reg`: one-entry Avalon-ST register slice (data+sop+eop) with ready/valid. It is reused in DELIVER and is available to other fabric blocks.

## Test plan
- HW_ADDR=1, DEVICE_COUNT=2, INPUT_COUNT=1: header 0x0001_0110 (hw 1, sw 1, port 1) + 2 payload -> port out of range; both discarded, `drop_count`=1, no `out_valid`.
- Header 0x0001_0001 + payloads 0xA, 0xB (EOP) with `out_ready`=1 -> out 0xA (SOP) then 0xB (EOP); `out_device`=0, `out_port`=0, `out_flag`=1; each beat appears 1 cycle after acceptance.
- Same packet with `out_ready` toggling 1,0,0,1 -> no beat lost or duplicated; `in_ready` deasserts while the register is full and unread.
- Header 0x0000_0000 (wrong hw_addr) + 3 beats followed by a valid packet back-to-back -> first packet dropped (`drop_count`=1), second delivered intact.
- Header-only packet (SOP+EOP), then 2 stray non-SOP beats -> `drop_count`=3, no output.
- Assert `reset` during the second payload beat of 4 -> `out_valid`=0 next cycle, the 2 remaining beats count as strays (`drop_count`=2), and the next valid packet is delivered normally.
